shift_unit: RTL and testbench

//   Parametrised multi-mode shifter: WIDTH-bit data register plus carry flag.

---
 rtl/shift_unit_if.sv | 26 ++
 rtl/shift_unit.sv | 115 +++++++++++
 tb/tb_shift_unit.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/shift_unit_if.sv
// Handshake and data bundle between the sequencer (master) and the shift unit (slave).
interface shift_unit_if #(
    parameter int WIDTH   = 8,
    parameter int SHAMT_W = 4
);
    logic               load;
    logic [WIDTH-1:0]   din;
    logic               start;
    logic [2:0]         op;
    logic [SHAMT_W-1:0] amt;
    logic [WIDTH-1:0]   so;
    logic               carry;
    logic               zero;
    logic               busy;
    logic               done;

    modport master (
        output load, din, start, op, amt,
        input  so, carry, zero, busy, done
    );

    modport slave (
        input  load, din, start, op, amt,
        output so, carry, zero, busy, done
    );
endinterface

// File: rtl/shift_unit.sv
// Multi-mode one-bit-per-clock shifter with carry flag and start/busy/done handshake.
// WIDTH and SHAMT_W must match the parameters of the connected shift_unit_if.
module shift_unit #(
    parameter int WIDTH   = 8,
    parameter int SHAMT_W = 4
) (
    input  logic         clk,
    input  logic         rst,
    shift_unit_if.slave  bus
);
    localparam logic [2:0] OP_SHL = 3'b000;
    localparam logic [2:0] OP_SHR = 3'b001;
    localparam logic [2:0] OP_SAR = 3'b010;
    localparam logic [2:0] OP_ROL = 3'b011;
    localparam logic [2:0] OP_ROR = 3'b100;
    localparam logic [2:0] OP_RCL = 3'b101;
    localparam logic [2:0] OP_RCR = 3'b110;
    localparam logic [2:0] OP_NOP = 3'b111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state_r;
    logic [SHAMT_W-1:0] cnt_r;
    logic [2:0]         op_r;
    logic [WIDTH-1:0]   q_r;
    logic               c_r;
    logic               busy_r;
    logic               done_r;

    // One single-bit step; result is packed as {carry, data}.
    function automatic logic [WIDTH:0] step_f(input logic [2:0] op,
                                              input logic [WIDTH-1:0] q,
                                              input logic c);
        logic [WIDTH:0] r;
        case (op)
            OP_SHL:  r = {q, 1'b0};
            OP_SHR:  r = {q[0], 1'b0, q[WIDTH-1:1]};
            OP_SAR:  r = {q[0], q[WIDTH-1], q[WIDTH-1:1]};
            OP_ROL:  r = {q[WIDTH-1], q[WIDTH-2:0], q[WIDTH-1]};
            OP_ROR:  r = {q[0], q[0], q[WIDTH-1:1]};
            OP_RCL:  r = {q, c};
            OP_RCR:  r = {q[0], c, q[WIDTH-1:1]};
            default: r = {c, q};
        endcase
        return r;
    endfunction

    // Control FSM, data/carry registers and registered handshake outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            cnt_r   <= {SHAMT_W{1'b0}};
            op_r    <= OP_NOP;
            q_r     <= {WIDTH{1'b0}};
            c_r     <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    done_r <= 1'b0;
                    busy_r <= 1'b0;
                    // A load in the same cycle as start takes priority and drops the start.
                    if (bus.load) begin
                        q_r     <= bus.din;
                        state_r <= IDLE;
                    end else if (bus.start) begin
                        op_r  <= bus.op;
                        cnt_r <= bus.amt;
                        if ((bus.amt == {SHAMT_W{1'b0}}) || (bus.op == OP_NOP)) begin
                            state_r <= DONE;
                            done_r  <= 1'b1;
                        end else begin
                            state_r <= SHIFT;
                            busy_r  <= 1'b1;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                SHIFT: begin
                    {c_r, q_r} <= step_f(op_r, q_r, c_r);
                    cnt_r      <= cnt_r - SHAMT_W'(1);
                    if (cnt_r == SHAMT_W'(1)) begin
                        state_r <= DONE;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                    end else begin
                        state_r <= SHIFT;
                    end
                end
                DONE: begin
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.so    = q_r;
    assign bus.carry = c_r;
    assign bus.zero  = (q_r == {WIDTH{1'b0}});
    assign bus.busy  = busy_r;
    assign bus.done  = done_r;
endmodule

// File: tb/tb_shift_unit.sv
// Directed plus randomized bench for shift_unit against a closed-form shift/rotate model.
module tb_shift_unit;
    localparam int W = 8;
    localparam int S = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;
    logic [7:0] m_q = 8'h00;
    logic       m_c = 1'b0;

    shift_unit_if #(.WIDTH(W), .SHAMT_W(S)) bus ();
    shift_unit #(.WIDTH(W), .SHAMT_W(S)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    // Closed-form result of n steps, returned as {carry, data}.
    function automatic logic [8:0] model(input logic [2:0] o, input int n,
                                         input logic [7:0] q, input logic c);
        int uq, sq, nq, nc, v, r;
        uq = int'(q);
        sq = int'($signed(q));
        v  = int'({c, q});
        nq = uq;
        nc = int'(c);
        if (n != 0) begin
            case (o)
                3'd0: begin nq = (uq << n) & 255; nc = (n <= 8) ? ((uq >> (8 - n)) & 1) : 0; end
                3'd1: begin nq = uq >> n;         nc = (n <= 8) ? ((uq >> (n - 1)) & 1) : 0; end
                3'd2: begin nq = (sq >>> n) & 255; nc = (sq >>> (n - 1)) & 1; end
                3'd3: begin r = n % 8; nq = ((uq << r) | (uq >> (8 - r))) & 255; nc = nq & 1; end
                3'd4: begin r = n % 8; nq = ((uq >> r) | (uq << (8 - r))) & 255; nc = (nq >> 7) & 1; end
                3'd5: begin r = n % 9; v = ((v << r) | (v >> (9 - r))) & 511; nq = v & 255; nc = v >> 8; end
                3'd6: begin r = n % 9; v = ((v >> r) | (v << (9 - r))) & 511; nq = v & 255; nc = v >> 8; end
                default: begin nq = uq; nc = int'(c); end
            endcase
        end
        return {nc[0], nq[7:0]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic chk_regs(input string tag);
        chk({tag, "_so"},    32'(bus.so),    32'(m_q));
        chk({tag, "_carry"}, 32'(bus.carry), 32'(m_c));
        chk({tag, "_zero"},  32'(bus.zero),  32'(m_q == 8'h00));
    endtask

    task automatic do_load(input logic [7:0] d);
        @(negedge clk);
        bus.load = 1'b1;
        bus.din  = d;
        @(posedge clk); #1;
        bus.load = 1'b0;
        m_q = d;
        chk_regs("load");
    endtask

    task automatic run_op(input logic [2:0] o, input logic [3:0] a, input bit noise);
        logic [8:0] e;
        logic [7:0] q0;
        logic       c0;
        int         cyc;
        bit         sh;
        q0 = m_q;
        c0 = m_c;
        sh = (a != 4'd0) && (o != 3'd7);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = o;
        bus.amt   = a;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.op    = 3'($urandom);
        bus.amt   = 4'($urandom);
        chk("busy_e0", 32'(bus.busy), 32'(sh));
        chk("done_e0", 32'(bus.done), 32'(!sh));
        cyc = 0;
        while (bus.done !== 1'b1 && cyc < 20) begin
            if (noise) begin
                bus.start = 1'b1;
                bus.load  = 1'b1;
                bus.din   = 8'($urandom);
            end
            @(posedge clk); #1;
            bus.start = 1'b0;
            bus.load  = 1'b0;
            cyc++;
            if (bus.done !== 1'b1) begin
                e = model(o, cyc, q0, c0);
                chk("step_so",    32'(bus.so),    32'(e[7:0]));
                chk("step_carry", 32'(bus.carry), 32'(e[8]));
                chk("step_busy",  32'(bus.busy),  32'd1);
            end
        end
        chk("step_count", 32'(cyc), sh ? 32'(a) : 32'd0);
        e = model(o, int'(a), q0, c0);
        m_q = e[7:0];
        m_c = e[8];
        chk_regs("result");
        chk("busy_at_done", 32'(bus.busy), 32'd0);
        @(posedge clk); #1;
        chk("done_clear", 32'(bus.done), 32'd0);
        chk("busy_after", 32'(bus.busy), 32'd0);
    endtask

    initial begin
        bus.load  = 1'b0;
        bus.din   = 8'h00;
        bus.start = 1'b0;
        bus.op    = 3'd7;
        bus.amt   = 4'd0;
        #12;
        chk_regs("reset");
        chk("reset_busy", 32'(bus.busy), 32'd0);
        chk("reset_done", 32'(bus.done), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Directed scenarios
        do_load(8'h96); run_op(3'd0, 4'd3, 1'b0);
        chk("t1_so", 32'(bus.so), 32'h0000_00B0);
        do_load(8'h96); run_op(3'd2, 4'd2, 1'b0);
        chk("t2_so", 32'(bus.so), 32'h0000_00E5);
        chk("t2_c", 32'(bus.carry), 32'd1);
        run_op(3'd1, 4'd0, 1'b0);
        do_load(8'h81); run_op(3'd3, 4'd9, 1'b0);
        chk("t3_so", 32'(bus.so), 32'h0000_0003);
        do_load(8'h00); run_op(3'd0, 4'd1, 1'b0);
        do_load(8'h01); run_op(3'd6, 4'd2, 1'b0);
        chk("t4_so", 32'(bus.so), 32'h0000_0080);
        do_load(8'h0F); run_op(3'd1, 4'd4, 1'b0);
        chk("t5_zero", 32'(bus.zero), 32'd1);

        // load and start together: load wins
        @(negedge clk);
        bus.load = 1'b1; bus.start = 1'b1; bus.din = 8'h5A; bus.op = 3'd0; bus.amt = 4'd3;
        @(posedge clk); #1;
        bus.load = 1'b0; bus.start = 1'b0;
        m_q = 8'h5A;
        chk_regs("ldst");
        chk("ldst_busy", 32'(bus.busy), 32'd0);
        chk("ldst_done", 32'(bus.done), 32'd0);
        @(posedge clk); #1;
        chk("ldst_busy2", 32'(bus.busy), 32'd0);
        chk("ldst_done2", 32'(bus.done), 32'd0);

        // asynchronous reset in the middle of a long shift
        @(negedge clk);
        bus.start = 1'b1; bus.op = 3'd0; bus.amt = 4'd15;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (5) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        m_q = 8'h00; m_c = 1'b0;
        chk_regs("midrst");
        chk("midrst_busy", 32'(bus.busy), 32'd0);
        chk("midrst_done", 32'(bus.done), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // start/load while busy must not disturb the running operation
        do_load(8'hC3); run_op(3'd0, 4'd15, 1'b1);
        do_load(8'hA5); run_op(3'd5, 4'd11, 1'b1);

        // Randomized operations
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                do_load(8'($urandom));
            end else begin
                run_op(3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)),
                       1'($urandom_range(0, 1)));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
